addr8u_residue_checker: RTL and testbench
=========================================

ADDR8U_RESIDUE_CHECKER -- requirements
Module: addr8u_residue_checker

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles the adder is given to settle after operands are driven (range 1-15).
REQ-002 Parameter MAX_RETRY, default 2: re-evaluations allowed after a residue mismatch (range 0-7).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered by the upstream stage.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_a, in_b  input  8 each  unsigned operands.
REQ-008 add_a, add_b  output  8 each  registered operands driven to the combinational 8-bit adder.
REQ-009 add_sum  input  9  adder result O[8:0], with O[8] as carry-out.
REQ-010 out_valid  output  1  checked result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_sum  output  9  captured adder result.
REQ-013 out_err  output  1  result failed the residue check after all retries.
REQ-014 err_count  output  8  saturating count of residue mismatches, including retried ones.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SETTLE, CHECK, HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1.
REQ-017 On transfer, the block SHALL register in_a/in_b onto add_a/add_b, load the settle counter with SETTLE_CYC, clear the retry counter, and enter SETTLE.
REQ-018 In SETTLE, the counter SHALL decrement each cycle; when it reaches 1, the state SHALL go to CHECK.
REQ-019 In CHECK, the block SHALL sample add_sum and compare ((add_a mod 3) + (add_b mod 3)) mod 3 against (add_sum mod 3); all residues are computed over the full 9-bit sum.
REQ-020 Match: out_sum <= add_sum, out_err <= 0, enter HOLD.
REQ-021 Mismatch with retry count < MAX_RETRY: increment err_count, increment the retry counter, reload the settle counter, return to SETTLE; add_a/add_b are unchanged.
REQ-022 Mismatch with retry count = MAX_RETRY: increment err_count, out_sum <= add_sum, out_err <= 1, enter HOLD.
REQ-023 In HOLD, out_valid SHALL be 1 and out_sum/out_err SHALL stay stable until out_ready=1; on that edge the state SHALL go to IDLE.
REQ-024 out_valid SHALL be 0 in every state other than HOLD.
REQ-025 There is no bypass: a new operand is accepted no earlier than the cycle after the HOLD handshake.
REQ-026 Latency from the transfer edge to out_valid, with no retries, SHALL be SETTLE_CYC+1 cycles.
REQ-027 err_count SHALL saturate at 255 and never wrap.
REQ-028 With MAX_RETRY=0, the first mismatch SHALL go straight to HOLD with out_err=1.

Reset
REQ-029 While rst_n=0, the block SHALL be forced to: state IDLE, in_ready 1, out_valid 0, out_err 0, out_sum 0, add_a/add_b 0, err_count 0, counters 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no output handshake; release of rst_n SHALL be synchronised so the first active edge after deassertion is clean.

Structure
REQ-031 The state enum, residue width and err_count width SHALL live in shared package addr8u_pkg.
REQ-032 The mod-3 residue SHALL be a reusable sub-module res3 (input width parameterised, 2-bit output), with one instance each for add_a, add_b and add_sum.
REQ-033 The adder itself SHALL stay outside this block; the bench instantiates one of the pareto adder variants and connects add_a/add_b/add_sum.

Verification
REQ-034 Correct adder, in_a=0xFF, in_b=0x01, SETTLE_CYC=2 -> out_valid 3 cycles after transfer, out_sum=0x100, out_err=0, err_count=0.
REQ-035 add_sum forced to 0x0FF for in_a=0x80, in_b=0x80, MAX_RETRY=2 -> 3 CHECK visits, out_err=1, out_sum=0x0FF, err_count=3.
REQ-036 Transient fault: add_sum wrong on the first CHECK only, in_a=0x12, in_b=0x34 -> out_sum=0x046, out_err=0, err_count=1, latency 6 cycles.
REQ-037 out_ready held 0 for 5 cycles in HOLD -> out_sum/out_valid stable throughout and in_ready=0; with in_valid asserted, the next transfer happens only after the handshake.
REQ-038 rst_n pulsed low during SETTLE -> all outputs return to their reset values immediately, and no out_valid is produced for the abandoned operands.
REQ-039 300 forced mismatches -> err_count=255 and stays there.

Source files
------------

// File: rtl/addr8u_pkg.sv
// rtl/addr8u_pkg.sv - shared types and helpers for the 8-bit adder residue checker
package addr8u_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int RES_W = 2;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Both operands are residues in 0..2, so a single conditional subtract suffices.
    function automatic logic [RES_W-1:0] mod3_add(input logic [RES_W-1:0] x,
                                                   input logic [RES_W-1:0] y);
        logic [RES_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/res3.sv
// rtl/res3.sv - combinational mod-3 residue of a W-bit unsigned value
module res3
    import addr8u_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]     din,
    output logic [RES_W-1:0] res
);

    // 2^i mod 3 alternates 1,2,1,2,... so each set bit adds its weight into the residue.
    always_comb begin
        res = '0;
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                res = mod3_add(res, (i % 2 == 0) ? 2'd1 : 2'd2);
            end
        end
    end

endmodule

// File: rtl/addr8u_residue_checker.sv
// rtl/addr8u_residue_checker.sv - drives an external 8-bit adder and checks its sum by mod-3 residue
module addr8u_residue_checker
    import addr8u_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [8:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_sum,
    output logic             out_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    logic [1:0]       rst_sync;
    logic             rst_ok;
    state_t           state;
    state_t           state_nxt;
    logic [3:0]       settle_cnt;
    logic [2:0]       retry_cnt;
    logic [RES_W-1:0] res_a;
    logic [RES_W-1:0] res_b;
    logic [RES_W-1:0] res_s;
    logic             mismatch;
    logic             retry_left;
    logic             take;

    // Assert asynchronously, release two edges later so no flop sees a runt deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_ok = rst_sync[1];

    res3 #(.W(8)) u_res_a (.din(add_a),   .res(res_a));
    res3 #(.W(8)) u_res_b (.din(add_b),   .res(res_b));
    res3 #(.W(9)) u_res_s (.din(add_sum), .res(res_s));

    assign mismatch   = (mod3_add(res_a, res_b) != res_s);
    assign retry_left = (retry_cnt < RETRY_MAX);
    assign take       = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (rst_ok) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt <= 4'd1) state_nxt = CHECK;
            CHECK:   state_nxt = (mismatch && retry_left) ? SETTLE : HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Offer in_ready during reset, but not while the release is still synchronising.
    always_comb begin
        in_ready  = (state == IDLE) && (rst_ok || !rst_n);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= '0;
            add_b      <= '0;
            settle_cnt <= '0;
            retry_cnt  <= '0;
            out_sum    <= '0;
            out_err    <= 1'b0;
            err_count  <= '0;
        end else if (rst_ok) begin
            case (state)
                IDLE: begin
                    if (take) begin
                        add_a      <= in_a;
                        add_b      <= in_b;
                        settle_cnt <= SETTLE_LD;
                        retry_cnt  <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 8'd1;
                    end
                    if (mismatch && retry_left) begin
                        retry_cnt  <= retry_cnt + 3'd1;
                        settle_cnt <= SETTLE_LD;
                    end else begin
                        out_sum <= add_sum;
                        out_err <= mismatch;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr8u_residue_checker.sv
// tb/tb_addr8u_residue_checker.sv - self-checking bench for addr8u_residue_checker
module tb_addr8u_residue_checker;

    localparam int S   = 2;
    localparam int MR  = 2;
    localparam int S0  = 1;
    localparam int MR0 = 0;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, out_err;
    logic [7:0] in_a, in_b, add_a, add_b, err_count;
    logic [8:0] add_sum, out_sum, fault_val;
    logic       faulty;

    logic       in_valid0, in_ready0, out_valid0, out_ready0, out_err0;
    logic [7:0] in_a0, in_b0, add_a0, add_b0, err_count0;
    logic [8:0] add_sum0, out_sum0, fault_val0;
    logic       faulty0;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_cnt0 = 0;
    int nbad_edges = 0;

    always #5 clk = ~clk;

    assign add_sum  = faulty  ? fault_val  : ({1'b0, add_a}  + {1'b0, add_b});
    assign add_sum0 = faulty0 ? fault_val0 : ({1'b0, add_a0} + {1'b0, add_b0});

    addr8u_residue_checker #(.SETTLE_CYC(S), .MAX_RETRY(MR)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_err(out_err), .err_count(err_count)
    );

    addr8u_residue_checker #(.SETTLE_CYC(S0), .MAX_RETRY(MR0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .add_a(add_a0), .add_b(add_b0), .add_sum(add_sum0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_sum(out_sum0),
        .out_err(out_err0), .err_count(err_count0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Attempt k sees the faulty sum while k < nb; a residue match ends the operation.
    task automatic model(input int a, input int b, input int nb, input int fv,
                         input int mr, input int s,
                         output int sum, output int err, output int mism, output int lat);
        int good;
        int seen;
        good = a + b;
        mism = 0;
        sum  = 0;
        err  = 0;
        lat  = 0;
        for (int k = 0; k <= mr; k++) begin
            seen = (k < nb) ? fv : good;
            lat  = (k + 1) * (s + 1);
            if ((seen % 3) == (((a % 3) + (b % 3)) % 3)) begin
                sum = seen;
                err = 0;
                break;
            end
            mism++;
            if (k == mr) begin
                sum = seen;
                err = 1;
            end
        end
    endtask

    task automatic run_txn(input int a, input int b, input int nb, input int fv, input int rd);
        int esum, eerr, emism, elat, n;
        model(a, b, nb, fv, MR, S, esum, eerr, emism, elat);
        exp_cnt = (exp_cnt + emism > 255) ? 255 : exp_cnt + emism;
        @(negedge clk);
        in_a = a[7:0]; in_b = b[7:0]; in_valid = 1'b1;
        fault_val = fv[8:0]; nbad_edges = nb * (S + 1);
        check("in_ready_idle", 32'(in_ready), 1);
        @(posedge clk);
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 200) begin
            faulty = (n + 1 <= nbad_edges);
            @(posedge clk); n++; @(negedge clk);
        end
        faulty = 1'b0;
        check("latency", n, elat);
        check("out_sum", 32'(out_sum), esum);
        check("out_err", 32'(out_err), eerr);
        check("err_count", 32'(err_count), exp_cnt);
        for (int i = 0; i < rd; i++) begin
            in_a = ~a[7:0]; in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            check("hold_valid", 32'(out_valid), 1);
            check("hold_sum", 32'(out_sum), esum);
            check("hold_err", 32'(out_err), eerr);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_add_a", 32'(add_a), a[7:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 0);
        if (rd > 0) begin
            check("post_hs_in_ready", 32'(in_ready), 1);
            check("post_hs_add_a", 32'(add_a), a[7:0]);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_txn0(input int a, input int b, input int nb, input int fv);
        int esum, eerr, emism, elat, n;
        model(a, b, nb, fv, MR0, S0, esum, eerr, emism, elat);
        exp_cnt0 = (exp_cnt0 + emism > 255) ? 255 : exp_cnt0 + emism;
        @(negedge clk);
        in_a0 = a[7:0]; in_b0 = b[7:0]; in_valid0 = 1'b1; fault_val0 = fv[8:0];
        @(posedge clk);
        n = 0;
        @(negedge clk);
        in_valid0 = 1'b0;
        while (!out_valid0 && n < 200) begin
            faulty0 = (n + 1 <= nb * (S0 + 1));
            @(posedge clk); n++; @(negedge clk);
        end
        faulty0 = 1'b0;
        check("r0_latency", n, elat);
        check("r0_out_sum", 32'(out_sum0), esum);
        check("r0_out_err", 32'(out_err0), eerr);
        check("r0_err_count", 32'(err_count0), exp_cnt0);
        out_ready0 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready0 = 1'b0;
        check("r0_post_hs_valid", 32'(out_valid0), 0);
    endtask

    initial begin
        int a, b, seen_valid;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; faulty = 1'b0; fault_val = '0;
        in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; out_ready0 = 1'b0; faulty0 = 1'b0; fault_val0 = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_add_a", 32'(add_a), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst0_out_valid", 32'(out_valid0), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_txn(8'hFF, 8'h01, 0, 0, 0);
        run_txn(8'h80, 8'h80, 100, 9'h0FF, 0);
        run_txn(8'h12, 8'h34, 1, 9'h047, 0);
        run_txn(8'h33, 8'h44, 0, 0, 5);

        for (int t = 0; t < 20; t++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_txn(a, b, int'($urandom_range(0, 4)),
                    (a + b + int'($urandom_range(1, 511))) % 512, int'($urandom_range(0, 2)));
        end

        // Abandon an operation mid-SETTLE.
        @(negedge clk);
        in_a = 8'h55; in_b = 8'h22; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_sum", 32'(out_sum), 0);
        check("mid_rst_out_err", 32'(out_err), 0);
        check("mid_rst_add_a", 32'(add_a), 0);
        check("mid_rst_add_b", 32'(add_b), 0);
        check("mid_rst_err_count", 32'(err_count), 0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("abandoned_no_valid", seen_valid, 0);

        run_txn0(8'h10, 8'h20, 100, 9'h031);
        run_txn0(8'hC8, 8'h64, 0, 0);

        for (int t = 0; t < 100; t++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_txn(a, b, 100, (a + b + 1) % 512, 0);
        end
        run_txn(8'h01, 8'h02, 0, 0, 0);
        check("sat_err_count", 32'(err_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
